// File: rtl/nios2_debug_jtag_pkg.sv
// Shared types and constants for the Nios II debug virtual-JTAG driver.
package nios2_debug_jtag_pkg;

    localparam int unsigned DEF_DR_WIDTH = 38;
    localparam int unsigned DEF_IR_WIDTH = 2;
    localparam int unsigned DEF_TCK_DIV  = 2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_UIR  = 3'd1,
        ST_CDR  = 3'd2,
        ST_SDR  = 3'd3,
        ST_UDR  = 3'd4,
        ST_DONE = 3'd5
    } jtag_state_e;

    // Virtual-state strobe vector for a state, ordered {udr, sdr, cdr, uir, rti}.
    function automatic logic [4:0] state_strobes(jtag_state_e s);
        case (s)
            ST_UIR:  return 5'b00010;
            ST_CDR:  return 5'b00100;
            ST_SDR:  return 5'b01000;
            ST_UDR:  return 5'b10000;
            default: return 5'b00001;
        endcase
    endfunction

    // clk cycles from command acceptance to rsp_valid high.
    function automatic int unsigned scan_latency(int unsigned dr_width,
                                                 int unsigned tck_div,
                                                 bit skip_ir);
        return (dr_width + (skip_ir ? 32'd2 : 32'd3)) * 2 * tck_div;
    endfunction

endpackage

// File: rtl/nios2_debug_jtag_tck_gen.sv
// Divided TCK generator: TCK_DIV clk cycles low, then TCK_DIV cycles high.
// tck_rise_o / tck_fall_o are high in the clk cycle whose closing edge moves
// TCK up / down, so the FSM can act on the same edge the pin changes.
// Once a period has started high it always completes, so TCK never shows a
// partial period when enable_i drops.
module nios2_debug_jtag_tck_gen #(
    parameter int unsigned TCK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic enable_i,
    output logic tck_o,
    output logic tck_rise_o,
    output logic tck_fall_o
);

    localparam int unsigned CNT_W = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TCK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tck_q, tck_d;
    logic             phase_end;

    assign phase_end  = (cnt_q == CNT_LAST);
    assign tck_rise_o = enable_i && !tck_q && phase_end;
    assign tck_fall_o = tck_q && phase_end;
    assign tck_o      = tck_q;

    // Half-period counter: runs while enabled or while finishing a high phase.
    always_comb begin
        cnt_d = cnt_q;
        tck_d = tck_q;
        if (tck_q || enable_i) begin
            if (phase_end) begin
                cnt_d = '0;
                tck_d = !tck_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            cnt_d = '0;
        end
    end

    // Counter and TCK registers; TCK is held low through reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            tck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tck_q <= tck_d;
        end
    end

endmodule

// File: rtl/nios2_debug_jtag_driver.sv
// Virtual-JTAG initiator for the Nios II debug slave. Runs IR/DR scans
// (IDLE -> UIR -> CDR -> SDR -> UDR -> DONE) on a divided TCK.
// Handshakes: cmd and rsp are valid/ready pairs; a transfer happens on the
// clk edge where valid && ready, valid must hold until then, and payload is
// only meaningful while valid is high.
module nios2_debug_jtag_driver
    import nios2_debug_jtag_pkg::*;
#(
    parameter int unsigned DR_WIDTH = DEF_DR_WIDTH,
    parameter int unsigned IR_WIDTH = DEF_IR_WIDTH,
    parameter int unsigned TCK_DIV  = DEF_TCK_DIV
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic                cmd_skip_ir,
    input  logic [DR_WIDTH-1:0] cmd_dr,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DR_WIDTH-1:0] rsp_dr,
    output logic [IR_WIDTH-1:0] rsp_ir_out,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    input  logic [IR_WIDTH-1:0] vji_ir_out,
    output logic                vji_rti,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic [2:0]          dbg_state
);

    localparam int unsigned BIT_W = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DR_WIDTH - 1);

    jtag_state_e         state_q, state_d;
    logic [4:0]          strobe_q;
    logic [BIT_W-1:0]    bit_cnt_q;
    logic [DR_WIDTH-1:0] dr_q;
    logic [DR_WIDTH-1:0] shift_q;
    logic [DR_WIDTH-1:0] rsp_dr_q;
    logic [IR_WIDTH-1:0] ir_in_q;
    logic [IR_WIDTH-1:0] rsp_ir_out_q;
    logic                rsp_valid_q;
    logic                skip_q;
    logic                tdi_q;
    logic                tck_en;
    logic                tck_rise;
    logic                tck_fall;
    logic                accept;

    assign cmd_ready = (state_q == ST_IDLE) && !rsp_valid_q;
    assign accept    = cmd_valid && cmd_ready;
    assign tck_en    = (state_q != ST_IDLE) && (state_q != ST_DONE);

    nios2_debug_jtag_tck_gen #(
        .TCK_DIV (TCK_DIV)
    ) u_tck_gen (
        .clk        (clk),
        .reset      (reset),
        .enable_i   (tck_en),
        .tck_o      (vji_tck),
        .tck_rise_o (tck_rise),
        .tck_fall_o (tck_fall)
    );

    // Next state: every scan state ends on the edge that drives TCK low.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = cmd_skip_ir ? ST_CDR : ST_UIR;
            ST_UIR:  if (tck_fall) state_d = ST_CDR;
            ST_CDR:  if (tck_fall) state_d = ST_SDR;
            ST_SDR:  if (tck_fall && (bit_cnt_q == LAST_BIT)) state_d = ST_UDR;
            ST_UDR:  if (tck_fall) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state, registered strobes and the scan datapath.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            strobe_q     <= 5'b00001;
            bit_cnt_q    <= '0;
            dr_q         <= '0;
            shift_q      <= '0;
            rsp_dr_q     <= '0;
            ir_in_q      <= '0;
            rsp_ir_out_q <= '0;
            rsp_valid_q  <= 1'b0;
            skip_q       <= 1'b0;
            tdi_q        <= 1'b0;
        end else begin
            state_q  <= state_d;
            strobe_q <= state_strobes(state_d);

            if (accept) begin
                dr_q   <= cmd_dr;
                skip_q <= cmd_skip_ir;
                if (!cmd_skip_ir) ir_in_q <= cmd_ir;
            end

            // Present bit 0 as SDR begins; later bits on each SDR falling edge.
            if ((state_q == ST_CDR) && tck_fall) begin
                tdi_q     <= dr_q[0];
                dr_q      <= dr_q >> 1;
                bit_cnt_q <= '0;
            end
            if ((state_q == ST_SDR) && tck_fall) begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
                if (bit_cnt_q == LAST_BIT) begin
                    tdi_q <= 1'b0;
                end else begin
                    tdi_q <= dr_q[0];
                    dr_q  <= dr_q >> 1;
                end
            end

            // TDO enters at the top so sample i ends up in bit i.
            if ((state_q == ST_SDR) && tck_rise)
                shift_q <= {vji_tdo, shift_q[DR_WIDTH-1:1]};

            // IR status comes from UIR, or from CDR when UIR was skipped.
            if (tck_rise && ((state_q == ST_UIR) || ((state_q == ST_CDR) && skip_q)))
                rsp_ir_out_q <= vji_ir_out;

            if ((state_q == ST_UDR) && tck_fall) begin
                rsp_dr_q    <= shift_q;
                rsp_valid_q <= 1'b1;
            end else if (rsp_valid_q && rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign vji_rti    = strobe_q[0];
    assign vji_uir    = strobe_q[1];
    assign vji_cdr    = strobe_q[2];
    assign vji_sdr    = strobe_q[3];
    assign vji_udr    = strobe_q[4];
    assign vji_tdi    = tdi_q;
    assign vji_ir_in  = ir_in_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_dr     = rsp_dr_q;
    assign rsp_ir_out = rsp_ir_out_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_nios2_debug_jtag_driver.sv
// Directed bench for nios2_debug_jtag_driver: default instance against a
// behavioural 38-bit slave shift register, plus a TCK_DIV=1 instance with
// TDO looped back to TDI.
module tb_nios2_debug_jtag_driver;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // ---------------- default instance ----------------
    logic        cmd_valid, cmd_ready, cmd_skip_ir;
    logic [1:0]  cmd_ir;
    logic [37:0] cmd_dr;
    logic        rsp_valid, rsp_ready;
    logic [37:0] rsp_dr;
    logic [1:0]  rsp_ir_out;
    logic        vji_tck, vji_tdi, vji_tdo;
    logic [1:0]  vji_ir_in, vji_ir_out;
    logic        vji_rti, vji_uir, vji_cdr, vji_sdr, vji_udr;
    logic [2:0]  dbg_state;

    nios2_debug_jtag_driver dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir),
        .cmd_skip_ir(cmd_skip_ir), .cmd_dr(cmd_dr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dr(rsp_dr),
        .rsp_ir_out(rsp_ir_out),
        .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_tdo(vji_tdo),
        .vji_ir_in(vji_ir_in), .vji_ir_out(vji_ir_out),
        .vji_rti(vji_rti), .vji_uir(vji_uir), .vji_cdr(vji_cdr),
        .vji_sdr(vji_sdr), .vji_udr(vji_udr), .dbg_state(dbg_state)
    );

    // ---------------- TCK_DIV=1 instance ----------------
    logic        d1_cmd_valid, d1_cmd_ready, d1_cmd_skip_ir;
    logic [1:0]  d1_cmd_ir;
    logic [37:0] d1_cmd_dr;
    logic        d1_rsp_valid, d1_rsp_ready;
    logic [37:0] d1_rsp_dr;
    logic [1:0]  d1_rsp_ir_out;
    logic        d1_vji_tck, d1_vji_tdi, d1_vji_tdo;
    logic [1:0]  d1_vji_ir_in, d1_vji_ir_out;
    logic        d1_vji_rti, d1_vji_uir, d1_vji_cdr, d1_vji_sdr, d1_vji_udr;
    logic [2:0]  d1_dbg_state;

    assign d1_vji_tdo = d1_vji_tdi;

    nios2_debug_jtag_driver #(.DR_WIDTH(38), .IR_WIDTH(2), .TCK_DIV(1)) dut1 (
        .clk(clk), .reset(reset),
        .cmd_valid(d1_cmd_valid), .cmd_ready(d1_cmd_ready), .cmd_ir(d1_cmd_ir),
        .cmd_skip_ir(d1_cmd_skip_ir), .cmd_dr(d1_cmd_dr),
        .rsp_valid(d1_rsp_valid), .rsp_ready(d1_rsp_ready), .rsp_dr(d1_rsp_dr),
        .rsp_ir_out(d1_rsp_ir_out),
        .vji_tck(d1_vji_tck), .vji_tdi(d1_vji_tdi), .vji_tdo(d1_vji_tdo),
        .vji_ir_in(d1_vji_ir_in), .vji_ir_out(d1_vji_ir_out),
        .vji_rti(d1_vji_rti), .vji_uir(d1_vji_uir), .vji_cdr(d1_vji_cdr),
        .vji_sdr(d1_vji_sdr), .vji_udr(d1_vji_udr), .dbg_state(d1_dbg_state)
    );

    // ---------------- behavioural slave DR ----------------
    logic [37:0] slave_q;
    logic [37:0] slave_init;
    logic        slave_load = 1'b0;

    assign vji_tdo = slave_q[0];

    always @(posedge vji_tck or posedge slave_load) begin
        if (slave_load) slave_q = slave_init;
        else if (vji_sdr) slave_q = {vji_tdi, slave_q[37:1]};
    end

    // ---------------- strobe / TCK monitor ----------------
    logic mon_en  = 1'b0;
    logic mon_clr = 1'b0;
    int   n_uir, n_cdr, n_sdr, n_udr, n_hot_err, n_tck_rise;

    always @(negedge clk) begin
        if (mon_clr) begin
            n_uir = 0; n_cdr = 0; n_sdr = 0; n_udr = 0; n_hot_err = 0;
        end else if (mon_en) begin
            n_uir += int'(vji_uir);
            n_cdr += int'(vji_cdr);
            n_sdr += int'(vji_sdr);
            n_udr += int'(vji_udr);
            if ($countones({vji_rti, vji_uir, vji_cdr, vji_sdr, vji_udr}) != 1) n_hot_err++;
        end
    end

    always @(posedge vji_tck or posedge mon_clr) begin
        if (mon_clr) n_tck_rise = 0;
        else if (mon_en) n_tck_rise++;
    end

    // ---------------- scoreboard counters ----------------
    int errors = 0;
    int checks = 0;

    // ---------------- driver tasks ----------------
    task automatic preload(input logic [37:0] v);
        slave_init = v;
        slave_load = 1'b1;
        #1;
        slave_load = 1'b0;
    endtask

    task automatic mon_start();
        mon_clr = 1'b1;
        @(negedge clk);
        #1;
        mon_clr = 1'b0;
        mon_en  = 1'b1;
    endtask

    // Returns #1 after the acceptance edge, with the cmd inputs scrambled.
    task automatic start_scan(input logic [1:0] ir, input logic skip, input logic [37:0] dr);
        int guard;
        cmd_ir      = ir;
        cmd_skip_ir = skip;
        cmd_dr      = dr;
        cmd_valid   = 1'b1;
        guard = 0;
        while (!cmd_ready && guard < 300) begin
            @(posedge clk); #1; guard++;
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_ir    = ~ir;
        cmd_dr    = ~dr;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 400) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic handshake(input string name);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        checks++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin
            errors++;
            $display("FAIL %s_handshake: {rsp_valid,cmd_ready} got %b want 01", name, {rsp_valid, cmd_ready});
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        cmd_valid = 1'b0; cmd_ir = '0; cmd_skip_ir = 1'b0; cmd_dr = '0; rsp_ready = 1'b0;
        vji_ir_out = '0;
        d1_cmd_valid = 1'b0; d1_cmd_ir = '0; d1_cmd_skip_ir = 1'b0; d1_cmd_dr = '0;
        d1_rsp_ready = 1'b0; d1_vji_ir_out = '0;
        preload('0);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({cmd_ready, rsp_valid, vji_rti, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_tck, vji_tdi} !== 9'b1_0_1_0000_0_0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 101000000",
                     {cmd_ready, rsp_valid, vji_rti, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_tck, vji_tdi});
        end
        checks++;
        if ({vji_ir_in, rsp_ir_out} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ir: {ir_in,rsp_ir_out} got %b want 0000", {vji_ir_in, rsp_ir_out});
        end
        checks++;
        if (rsp_dr !== 38'h0) begin
            errors++;
            $display("FAIL reset_rsp_dr: got %h want 0", rsp_dr);
        end
        checks++;
        if ({d1_cmd_ready, d1_rsp_valid, d1_vji_rti, d1_vji_uir, d1_vji_cdr, d1_vji_sdr, d1_vji_udr, d1_vji_tck, d1_vji_tdi} !== 9'b1_0_1_0000_0_0) begin
            errors++;
            $display("FAIL reset_ctrl_div1: got %b want 101000000",
                     {d1_cmd_ready, d1_rsp_valid, d1_vji_rti, d1_vji_uir, d1_vji_cdr, d1_vji_sdr, d1_vji_udr, d1_vji_tck, d1_vji_tdi});
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_loopback();
        int lat;
        vji_ir_out = 2'b01;
        preload(38'h2A_5555_AAAA);
        mon_start();
        start_scan(2'b01, 1'b0, 38'h15_0F0F_F0F0);
        wait_rsp(lat);
        mon_en = 1'b0;
        checks++;
        if (lat !== 164) begin errors++; $display("FAIL loop_latency: got %0d want 164", lat); end
        checks++;
        if (rsp_dr !== 38'h2A_5555_AAAA) begin errors++; $display("FAIL loop_rsp_dr: got %h want 2a5555aaaa", rsp_dr); end
        checks++;
        if (slave_q !== 38'h15_0F0F_F0F0) begin errors++; $display("FAIL loop_slave_dr: got %h want 150f0ff0f0", slave_q); end
        checks++;
        if ({vji_ir_in, rsp_ir_out} !== 4'b0101) begin
            errors++; $display("FAIL loop_ir: {ir_in,rsp_ir_out} got %b want 0101", {vji_ir_in, rsp_ir_out});
        end
        checks++;
        if (n_uir !== 4 || n_cdr !== 4 || n_sdr !== 152 || n_udr !== 4) begin
            errors++;
            $display("FAIL loop_strobe_len: uir=%0d cdr=%0d sdr=%0d udr=%0d want 4/4/152/4", n_uir, n_cdr, n_sdr, n_udr);
        end
        checks++;
        if (n_hot_err !== 0) begin errors++; $display("FAIL loop_onehot: %0d bad cycles want 0", n_hot_err); end
        checks++;
        if (n_tck_rise !== 41) begin errors++; $display("FAIL loop_tck_rises: got %0d want 41", n_tck_rise); end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({rsp_valid, vji_tck, vji_rti, cmd_ready} !== 4'b1010 || rsp_dr !== 38'h2A_5555_AAAA) begin
            errors++;
            $display("FAIL loop_hold: {valid,tck,rti,ready} got %b want 1010, rsp_dr %h", {rsp_valid, vji_tck, vji_rti, cmd_ready}, rsp_dr);
        end
        handshake("loop");
    endtask

    task automatic test_skip_ir();
        int lat;
        vji_ir_out = 2'b10;
        preload(38'h00_1234_5678);
        start_scan(2'b10, 1'b0, 38'h3F_0000_FFFF);
        wait_rsp(lat);
        checks++;
        if (vji_ir_in !== 2'b10) begin errors++; $display("FAIL skip_prior_ir: got %b want 10", vji_ir_in); end
        handshake("skip_prior");
        vji_ir_out = 2'b11;
        preload(38'h21_8421_8421);
        mon_start();
        start_scan(2'b01, 1'b1, 38'h0A_BCDE_F012);
        wait_rsp(lat);
        mon_en = 1'b0;
        checks++;
        if (lat !== 160) begin errors++; $display("FAIL skip_latency: got %0d want 160", lat); end
        checks++;
        if (n_uir !== 0 || n_cdr !== 4 || n_sdr !== 152 || n_hot_err !== 0) begin
            errors++;
            $display("FAIL skip_strobes: uir=%0d cdr=%0d sdr=%0d hot_err=%0d want 0/4/152/0", n_uir, n_cdr, n_sdr, n_hot_err);
        end
        checks++;
        if ({vji_ir_in, rsp_ir_out} !== 4'b1011) begin
            errors++; $display("FAIL skip_ir: {ir_in,rsp_ir_out} got %b want 1011", {vji_ir_in, rsp_ir_out});
        end
        checks++;
        if (rsp_dr !== 38'h21_8421_8421 || slave_q !== 38'h0A_BCDE_F012) begin
            errors++; $display("FAIL skip_data: rsp_dr %h want 2184218421, slave %h want 0abcdef012", rsp_dr, slave_q);
        end
        handshake("skip");
    endtask

    task automatic test_back_pressure();
        int lat;
        int bad;
        vji_ir_out = 2'b00;
        preload(38'h12_3456_789A);
        start_scan(2'b11, 1'b0, 38'h01_0203_0405);
        wait_rsp(lat);
        cmd_ir = 2'b10; cmd_skip_ir = 1'b0; cmd_dr = 38'h3A_AAAA_5555; cmd_valid = 1'b1;
        bad = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (cmd_ready !== 1'b0 || vji_tck !== 1'b0 || rsp_valid !== 1'b1 || vji_rti !== 1'b1) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL bp_stall: %0d bad cycles want 0", bad); end
        checks++;
        if (rsp_dr !== 38'h12_3456_789A) begin errors++; $display("FAIL bp_hold_dr: got %h want 123456789a", rsp_dr); end
        preload(38'h05_5AA5_0FF0);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        checks++;
        if ({rsp_valid, cmd_ready, vji_rti} !== 3'b011) begin
            errors++; $display("FAIL bp_release: {valid,ready,rti} got %b want 011", {rsp_valid, cmd_ready, vji_rti});
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_dr = '0;
        checks++;
        if ({cmd_ready, vji_uir, vji_rti} !== 3'b010) begin
            errors++; $display("FAIL bp_next_start: {ready,uir,rti} got %b want 010", {cmd_ready, vji_uir, vji_rti});
        end
        wait_rsp(lat);
        checks++;
        if (lat !== 164 || rsp_dr !== 38'h05_5AA5_0FF0 || slave_q !== 38'h3A_AAAA_5555 || vji_ir_in !== 2'b10) begin
            errors++;
            $display("FAIL bp_next_scan: lat %0d want 164, rsp_dr %h want 055aa50ff0, slave %h want 3aaaaa5555, ir_in %b want 10",
                     lat, rsp_dr, slave_q, vji_ir_in);
        end
        handshake("bp");
    endtask

    task automatic test_reset_mid_scan();
        int lat;
        preload(38'h3F_FFFF_0000);
        start_scan(2'b11, 1'b0, 38'h00_FFFF_FFFF);
        repeat (78) @(posedge clk);
        #1;
        checks++;
        if ({vji_sdr, vji_tck} !== 2'b11) begin
            errors++; $display("FAIL midrst_pre: {sdr,tck} got %b want 11", {vji_sdr, vji_tck});
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({cmd_ready, rsp_valid, vji_rti, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_tck, vji_tdi} !== 9'b1_0_1_0000_0_0 || vji_ir_in !== 2'b00) begin
            errors++;
            $display("FAIL midrst_outputs: got %b want 101000000, ir_in %b want 00",
                     {cmd_ready, rsp_valid, vji_rti, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_tck, vji_tdi}, vji_ir_in);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if ({rsp_valid, cmd_ready, vji_tck} !== 3'b010) begin
            errors++; $display("FAIL midrst_no_rsp: {valid,ready,tck} got %b want 010", {rsp_valid, cmd_ready, vji_tck});
        end
        vji_ir_out = 2'b01;
        preload(38'h2B_CDEF_0123);
        start_scan(2'b01, 1'b0, 38'h14_3210_FEDC);
        wait_rsp(lat);
        checks++;
        if (lat !== 164 || rsp_dr !== 38'h2B_CDEF_0123 || slave_q !== 38'h14_3210_FEDC || rsp_ir_out !== 2'b01) begin
            errors++;
            $display("FAIL midrst_after: lat %0d want 164, rsp_dr %h want 2bcdef0123, slave %h want 143210fedc, ir_out %b want 01",
                     lat, rsp_dr, slave_q, rsp_ir_out);
        end
        handshake("midrst");
    endtask

    task automatic test_tck_div1();
        int   lat;
        int   hi;
        int   tog_err;
        logic prev;
        d1_vji_ir_out = 2'b11;
        d1_cmd_ir = 2'b10; d1_cmd_skip_ir = 1'b0; d1_cmd_dr = 38'h2D_B6DB_6DB6; d1_cmd_valid = 1'b1;
        checks++;
        if (d1_cmd_ready !== 1'b1) begin errors++; $display("FAIL div1_ready: got %b want 1", d1_cmd_ready); end
        @(posedge clk); #1;
        d1_cmd_valid = 1'b0;
        d1_cmd_dr = '0;
        d1_cmd_ir = 2'b00;
        lat = 0; hi = 0; tog_err = 0;
        prev = d1_vji_tck;
        while (!d1_rsp_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (lat < 82 || !d1_rsp_valid) begin
                if (d1_vji_tck === prev) tog_err++;
            end
            hi += int'(d1_vji_tck);
            prev = d1_vji_tck;
        end
        checks++;
        if (lat !== 82) begin errors++; $display("FAIL div1_latency: got %0d want 82", lat); end
        checks++;
        if (tog_err !== 0 || hi !== 41) begin
            errors++; $display("FAIL div1_tck: toggle errors %0d want 0, high cycles %0d want 41", tog_err, hi);
        end
        checks++;
        if ({d1_rsp_ir_out, d1_vji_ir_in} !== 4'b1110) begin
            errors++; $display("FAIL div1_ir: {rsp_ir_out,ir_in} got %b want 1110", {d1_rsp_ir_out, d1_vji_ir_in});
        end
        checks++;
        if (d1_rsp_dr !== 38'h2D_B6DB_6DB6) begin errors++; $display("FAIL div1_rsp_dr: got %h want 2db6db6db6", d1_rsp_dr); end
        d1_rsp_ready = 1'b1;
        @(posedge clk); #1;
        d1_rsp_ready = 1'b0;
        checks++;
        if ({d1_rsp_valid, d1_cmd_ready} !== 2'b01) begin
            errors++; $display("FAIL div1_handshake: {valid,ready} got %b want 01", {d1_rsp_valid, d1_cmd_ready});
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_loopback();
        test_skip_ir();
        test_back_pressure();
        test_reset_mid_scan();
        test_tck_div1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
